// File: rtl/mmss_pkg.sv
// Shared types, constants and BCD helpers for the mm:ss countdown timer.
package mmss_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_59   = 8'h59;

    // Two-digit BCD decrement; callers never pass 00.
    function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'h9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Invalid digits or out-of-range values collapse to the bound.
    function automatic logic [7:0] bcd_clamp8(input logic [7:0] v, input logic [7:0] bound);
        logic [7:0] r;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > bound)) begin
            r = bound;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mmss_countdown_if.sv
// Control and status bundle between the countdown timer and its user.
interface mmss_countdown_if;
    logic       en;
    logic       load;
    logic [7:0] ld_min;
    logic [7:0] ld_sec;
    logic       start;
    logic       pause;
    logic [7:0] min;
    logic [7:0] sec;
    logic       bout;
    logic       busy;
    logic       done;

    modport master (
        output en, load, ld_min, ld_sec, start, pause,
        input  min, sec, bout, busy, done
    );

    modport slave (
        input  en, load, ld_min, ld_sec, start, pause,
        output min, sec, bout, busy, done
    );
endinterface

// File: rtl/m60_down.sv
// Mod-60 BCD down-counter: the decrementing twin of m60, wrapping 00->59 with a borrow pulse.
module m60_down
    import mmss_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [7:0] ld,
    input  logic       dec,
    output logic [7:0] cnt,
    output logic       bout
);

    logic [7:0] cnt_reg;
    logic       bout_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg  <= BCD_ZERO;
            bout_reg <= 1'b0;
        end else if (load) begin
            cnt_reg  <= bcd_clamp8(ld, BCD_59);
            bout_reg <= 1'b0;
        end else if (dec) begin
            if (cnt_reg == BCD_ZERO) begin
                cnt_reg  <= BCD_59;
                bout_reg <= 1'b1;
            end else begin
                cnt_reg  <= bcd_dec8(cnt_reg);
                bout_reg <= 1'b0;
            end
        end else begin
            bout_reg <= 1'b0;
        end
    end

    assign cnt  = cnt_reg;
    assign bout = bout_reg;

endmodule

// File: rtl/mmss_countdown.sv
// Loadable BCD mm:ss countdown with start/pause/resume, minute-borrow and expiry pulses.
module mmss_countdown
    import mmss_pkg::*;
#(
    parameter int         TICK_DIV = 1,
    parameter logic [7:0] MAX_MIN  = 8'h59
) (
    input  logic              clk,
    input  logic              rstn,
    mmss_countdown_if.slave   bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [7:0]    min_reg, min_next;
    logic          done_reg, done_next;
    logic          sec_load;
    logic          sec_dec;
    logic [7:0]    sec_cnt;
    logic          sec_bout;
    logic          value_zero;
    logic          last_step;

    assign value_zero = (min_reg == BCD_ZERO) && (sec_cnt == BCD_ZERO);
    assign last_step  = (min_reg == BCD_ZERO) && (sec_cnt == 8'h01);

    m60_down u_sec (
        .clk  (clk),
        .rstn (rstn),
        .load (sec_load),
        .ld   (bus.ld_sec),
        .dec  (sec_dec),
        .cnt  (sec_cnt),
        .bout (sec_bout)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            min_reg   <= BCD_ZERO;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            min_reg   <= min_next;
            done_reg  <= done_next;
        end
    end

    // Priority: load > pause > start > tick. A start or pause edge never also ticks.
    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        min_next   = min_reg;
        done_next  = 1'b0;
        sec_load   = 1'b0;
        sec_dec    = 1'b0;

        if (bus.load) begin
            state_next = IDLE;
            presc_next = '0;
            min_next   = bcd_clamp8(bus.ld_min, MAX_MIN);
            sec_load   = 1'b1;
        end else if (bus.pause && (state_reg == RUN)) begin
            state_next = HOLD;
        end else if (bus.start && (state_reg != RUN)) begin
            if (state_reg == HOLD) begin
                state_next = RUN;
            end else if (value_zero) begin
                done_next = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else if ((state_reg == RUN) && bus.en) begin
            if (presc_reg == PRESC_LAST) begin
                presc_next = '0;
                sec_dec    = 1'b1;
                if (sec_cnt == BCD_ZERO) begin
                    min_next = bcd_dec8(min_reg);
                end
                if (last_step) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end else begin
                presc_next = presc_reg + PW'(1);
            end
        end
    end

    assign bus.min  = min_reg;
    assign bus.sec  = sec_cnt;
    assign bus.bout = sec_bout;
    assign bus.busy = (state_reg != IDLE);
    assign bus.done = done_reg;

endmodule
